// File: rtl/mem_wb_multi_pkg.sv
// mem_wb_multi_pkg: shared pipeline defines and the stage action type for the MEM/WB register
package mem_wb_multi_pkg;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam logic RstEnable = 1'b1;
    localparam logic Enable = 1'b1;
    localparam logic Disable = 1'b0;
    localparam int StallRegBus = 6;
    localparam int RegBus = 16;
    localparam int RegAddrBus = 4;
    localparam logic [RegBus-1:0] ZeroWord = '0;
    localparam logic [RegAddrBus-1:0] DisableRegAddr = '0;
    typedef enum logic [1:0] {ACT_HOLD, ACT_BUBBLE, ACT_LOAD} wb_act_e;
endpackage

// File: rtl/mem_wb_multi_wb_collision_resolve.sv
// wb_collision_resolve: drops lower-channel write enables that target the same address as a higher channel
module wb_collision_resolve #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 4
) (
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    output logic [NUM_CH-1:0]        en_res,
    output logic                     collision
);
    always_comb begin
        en_res = en;
        for (int j = 0; j < NUM_CH; j++)
            for (int k = j + 1; k < NUM_CH; k++)
                if (en[j] && en[k] && addr[j*ADDR_W +: ADDR_W] == addr[k*ADDR_W +: ADDR_W])
                    en_res[j] = 1'b0;
        collision = |(en & ~en_res);
    end
endmodule

// File: rtl/mem_wb_multi.sv
// mem_wb_multi: multi-channel MEM/WB pipeline register with stall/flush, collision resolution and perf counters
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_CH  = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic                     valid_i,
    input  logic [NUM_CH*DATA_W-1:0] wData_i,
    input  logic [NUM_CH-1:0]        wReg_i,
    input  logic [NUM_CH*ADDR_W-1:0] wRegAddr_i,
    output logic                     valid_o,
    output logic [NUM_CH*DATA_W-1:0] wData_o,
    output logic [NUM_CH-1:0]        wReg_o,
    output logic [NUM_CH*ADDR_W-1:0] wRegAddr_o,
    output logic                     collision_o,
    output logic [CNT_W-1:0]         retire_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);
    logic s_self, s_next, coll;
    logic [NUM_CH-1:0] en_gated, en_res;
    wb_act_e act;
    assign s_self = stall[STAGE];
    // The last stage has no successor, so it can never be held by one.
    generate
        if (STAGE == STALL_W - 1) begin : g_last
            assign s_next = NoStop;
        end else begin : g_mid
            assign s_next = stall[STAGE+1];
        end
    endgenerate
    assign en_gated = valid_i ? wReg_i : '0;
    assign act = flush ? ACT_BUBBLE : !s_self ? ACT_LOAD : !s_next ? ACT_BUBBLE : ACT_HOLD;
    wb_collision_resolve #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_resolve (
        .en(en_gated),
        .addr(wRegAddr_i),
        .en_res(en_res),
        .collision(coll)
    );
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_o <= Disable;
            wData_o <= '0;
            wReg_o <= '0;
            wRegAddr_o <= '0;
            collision_o <= 1'b0;
            retire_cnt_o <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (act == ACT_BUBBLE) begin
                valid_o <= Disable;
                wData_o <= '0;
                wReg_o <= '0;
                wRegAddr_o <= '0;
                collision_o <= 1'b0;
                if (!flush)
                    bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, ~&bubble_cnt_o};
            end else if (act == ACT_LOAD) begin
                valid_o <= valid_i;
                wData_o <= wData_i;
                wReg_o <= en_res;
                wRegAddr_o <= wRegAddr_i;
                collision_o <= coll;
                if (valid_i)
                    retire_cnt_o <= retire_cnt_o + {{(CNT_W-1){1'b0}}, ~&retire_cnt_o};
            end
            // Clear wins over any increment scheduled above on the same edge.
            if (cnt_clr) begin
                retire_cnt_o <= '0;
                bubble_cnt_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_multi.sv
// tb_mem_wb_multi: scoreboard bench for mem_wb_multi, with a 3-bit counter copy for saturation
module tb_mem_wb_multi;
    logic clk = 1'b0;
    logic rst, flush, cnt_clr, valid_i;
    logic [5:0] stall;
    logic [31:0] wData_i, wData_o, s_data;
    logic [1:0] wReg_i, wReg_o, s_wreg;
    logic [7:0] wRegAddr_i, wRegAddr_o, s_addr;
    logic valid_o, collision_o, s_valid, s_coll;
    logic [31:0] retire_cnt_o, bubble_cnt_o;
    logic [2:0] s_ret, s_bub;

    typedef struct {
        logic [43:0] out;
        logic [31:0] ret;
        logic [31:0] bub;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_multi #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_i(valid_i), .wData_i(wData_i), .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i),
        .valid_o(valid_o), .wData_o(wData_o), .wReg_o(wReg_o), .wRegAddr_o(wRegAddr_o),
        .collision_o(collision_o), .retire_cnt_o(retire_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    mem_wb_multi #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_i(valid_i), .wData_i(wData_i), .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i),
        .valid_o(s_valid), .wData_o(s_data), .wReg_o(s_wreg), .wRegAddr_o(s_addr),
        .collision_o(s_coll), .retire_cnt_o(s_ret), .bubble_cnt_o(s_bub)
    );

    task automatic push(input logic v, input logic [1:0] wr, input logic c, input logic [31:0] d,
                        input logic [7:0] a, input int ret, input int bub);
        exp_t x;
        x.out = {v, wr, c, d, a};
        x.ret = ret;
        x.bub = bub;
        q.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; cnt_clr = 0; stall = 6'b0; valid_i = 1;
        wData_i = {16'hBEEF, 16'h1234}; wRegAddr_i = {4'd7, 4'd3}; wReg_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            push(0, 2'b00, 0, 32'h0, 8'h0, 0, 0);
            tick();
            e = q.pop_front();
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL reset outputs cycle %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL reset counters: got %0d/%0d want %0d/%0d", retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
        end
        rst = 0;
    endtask

    task automatic test_load;
        push(1, 2'b11, 0, 32'hBEEF1234, 8'h73, 1, 0);
        tick();
        e = q.pop_front();
        checks++;
        if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
            errors++;
            $display("FAIL load outputs: got %h want %h", {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
        end
        checks++;
        if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
            errors++;
            $display("FAIL load counters: got %0d/%0d want %0d/%0d", retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
        end
    endtask

    task automatic test_stall;
        stall = 6'b010000;
        push(0, 2'b00, 0, 32'h0, 8'h0, 1, 1);
        for (int i = 0; i < 3; i++) push(0, 2'b00, 0, 32'h0, 8'h0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            stall = 6'b110000;
            e = q.pop_front();
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL stall outputs step %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL stall counters step %0d: got %0d/%0d want %0d/%0d", i, retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
        end
        stall = 6'b0;
    endtask

    task automatic test_collision;
        wData_i = {16'h5555, 16'hAAAA}; wRegAddr_i = {4'd5, 4'd5}; wReg_i = 2'b11; valid_i = 1;
        push(1, 2'b10, 1, 32'h5555AAAA, 8'h55, 2, 1);
        push(1, 2'b11, 0, 32'h5555AAAA, 8'h65, 3, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            wRegAddr_i = {4'd6, 4'd5};
            e = q.pop_front();
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL collision outputs step %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL collision counters step %0d: got %0d/%0d want %0d/%0d", i, retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
        end
    endtask

    task automatic test_flush;
        stall = 6'b110000;
        wData_i = 32'hDEADDEAD; wRegAddr_i = 8'h99;
        push(1, 2'b11, 0, 32'h5555AAAA, 8'h65, 3, 1);
        push(0, 2'b00, 0, 32'h0, 8'h0, 3, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            flush = 1;
            e = q.pop_front();
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL flush outputs step %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL flush counters step %0d: got %0d/%0d want %0d/%0d", i, retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
        end
        flush = 0; stall = 6'b0;
    endtask

    task automatic test_invalid;
        valid_i = 0; wReg_i = 2'b11; wData_i = {16'h1111, 16'h2222}; wRegAddr_i = {4'd2, 4'd1};
        push(0, 2'b00, 0, 32'h11112222, 8'h21, 3, 1);
        tick();
        e = q.pop_front();
        checks++;
        if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
            errors++;
            $display("FAIL invalid outputs: got %h want %h", {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
        end
        checks++;
        if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
            errors++;
            $display("FAIL invalid counters: got %0d/%0d want %0d/%0d", retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
        end
        valid_i = 1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        wRegAddr_i = {4'd9, 4'd8}; wReg_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            wData_i = d;
            push(1, 2'b01, 0, d, 8'h98, 4 + i, 1);
            tick();
            e = q.pop_front();
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL b2b outputs step %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL b2b counters step %0d: got %0d/%0d want %0d/%0d", i, retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
            checks++;
            if (s_ret !== 3'(e.ret)) begin
                errors++;
                $display("FAIL b2b small retire step %0d: got %0d want %0d", i, s_ret, e.ret);
            end
        end
    endtask

    task automatic test_saturation;
        int want_s;
        wRegAddr_i = {4'd4, 4'd2}; wReg_i = 2'b11; wData_i = 32'hCAFE0001; valid_i = 1;
        cnt_clr = 1;
        push(1, 2'b11, 0, 32'hCAFE0001, 8'h42, 0, 0);
        for (int i = 1; i <= 9; i++) push(1, 2'b11, 0, 32'hCAFE0001, 8'h42, i, 0);
        push(1, 2'b11, 0, 32'hCAFE0001, 8'h42, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            tick();
            cnt_clr = (i == 9);
            e = q.pop_front();
            want_s = (e.ret > 7) ? 7 : e.ret;
            checks++;
            if ({valid_o, wReg_o, collision_o, wData_o, wRegAddr_o} !== e.out) begin
                errors++;
                $display("FAIL sat outputs step %0d: got %h want %h", i, {valid_o, wReg_o, collision_o, wData_o, wRegAddr_o}, e.out);
            end
            checks++;
            if (retire_cnt_o !== e.ret || bubble_cnt_o !== e.bub) begin
                errors++;
                $display("FAIL sat counters step %0d: got %0d/%0d want %0d/%0d", i, retire_cnt_o, bubble_cnt_o, e.ret, e.bub);
            end
            checks++;
            if (s_ret !== 3'(want_s)) begin
                errors++;
                $display("FAIL sat small retire step %0d: got %0d want %0d", i, s_ret, want_s);
            end
        end
        cnt_clr = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_collision();
        test_flush();
        test_invalid();
        test_back_to_back();
        test_saturation();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
